// File: rtl/bank_group_ctrl.sv
// bank_group_ctrl: per-bank ACT/PRE timing FSMs, command checker and CL read pipe.
// Define BANK_GROUP_ERRCNT_EN to add a saturating 16-bit err_count output.
module bank_group_ctrl #(
  parameter int BAWIDTH       = 2,
  parameter int BANKSPERGROUP = 2**BAWIDTH,
  parameter int COLWIDTH      = 10,
  parameter int CHWIDTH       = 5,
  parameter int TRCD          = 3,
  parameter int TRAS          = 6,
  parameter int TRP           = 3,
  parameter int CL            = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  input  logic [2:0]                        cmd,
  input  logic [BAWIDTH-1:0]                ba,
  input  logic [CHWIDTH-1:0]                addr_row,
  input  logic [COLWIDTH-1:0]               addr_col,
  output logic                              cmd_err,
  output logic [BANKSPERGROUP-1:0]          bank_open,
  output logic [BANKSPERGROUP*CHWIDTH-1:0]  open_row,
  output logic [BANKSPERGROUP-1:0]          rd_o_wr,
  output logic [BANKSPERGROUP*CHWIDTH-1:0]  row,
  output logic [BANKSPERGROUP*COLWIDTH-1:0] column,
  output logic                              rd_valid,
  output logic [BAWIDTH-1:0]                rd_ba
`ifdef BANK_GROUP_ERRCNT_EN
  ,
  output logic [15:0]                       err_count
`endif
);

  localparam int CW = 8;
  localparam logic [CW-1:0] RCD_L = CW'(TRCD - 1);
  localparam logic [CW-1:0] RAS_L = CW'(TRAS - 1);
  localparam logic [CW-1:0] RP_L  = CW'(TRP - 1);

  typedef enum logic [1:0] {
    IDLE,
    OPENING,
    ACTIVE,
    CLOSING
  } bst_t;

  bst_t          st   [BANKSPERGROUP];
  logic [CW-1:0] tcnt [BANKSPERGROUP];
  logic [CW-1:0] ras  [BANKSPERGROUP];

  logic [CL-1:0]      pv;
  logic [BAWIDTH-1:0] pb [CL];

  logic [BANKSPERGROUP-1:0] sel;
  logic [BANKSPERGROUP-1:0] act_st;
  logic [BANKSPERGROUP-1:0] idle_st;
  logic [BANKSPERGROUP-1:0] ras_ok;

  logic op_nop, op_act, op_rd, op_wr, op_pre, op_prea;
  logic go_act, go_rd, go_wr, go_pre, go_prea, err;

  always_comb begin
    act_st  = '0;
    idle_st = '0;
    ras_ok  = '0;
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      act_st[b]  = (st[b] == ACTIVE);
      idle_st[b] = (st[b] == IDLE);
      ras_ok[b]  = (ras[b] == '0);
    end
  end

  assign bank_open = act_st;
  assign row       = open_row;
  assign rd_valid  = pv[CL-1];
  assign rd_ba     = pb[CL-1];

  always_comb begin
    sel     = '0;
    sel[ba] = 1'b1;
    op_nop  = (cmd == 3'd0);
    op_act  = (cmd == 3'd1);
    op_rd   = (cmd == 3'd2);
    op_wr   = (cmd == 3'd3);
    op_pre  = (cmd == 3'd4);
    op_prea = (cmd == 3'd5);
    go_act  = 1'b0;
    go_rd   = 1'b0;
    go_wr   = 1'b0;
    go_pre  = 1'b0;
    go_prea = 1'b0;
    err     = 1'b0;
    if (cmd_valid) begin
      unique case (1'b1)
        op_nop: err = 1'b0;
        op_act: begin
          go_act = |(sel & idle_st);
          err    = ~go_act;
        end
        op_rd: begin
          go_rd = |(sel & act_st);
          err   = ~go_rd;
        end
        op_wr: begin
          go_wr = |(sel & act_st);
          err   = ~go_wr;
        end
        // PRE to an idle bank is accepted as a no-op
        op_pre: begin
          go_pre = |(sel & act_st & ras_ok);
          err    = ~go_pre & ~|(sel & idle_st);
        end
        op_prea: begin
          go_prea = &(~act_st | ras_ok);
          err     = ~go_prea;
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        st[b]   <= IDLE;
        tcnt[b] <= '0;
        ras[b]  <= '0;
      end
      for (int i = 0; i < CL; i++) pb[i] <= '0;
      pv       <= '0;
      open_row <= '0;
      column   <= '0;
      rd_o_wr  <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= err;
      rd_o_wr <= '0;
      pv[0]   <= go_rd;
      pb[0]   <= go_rd ? ba : '0;
      for (int i = 1; i < CL; i++) begin
        pv[i] <= pv[i-1];
        pb[i] <= pb[i-1];
      end
      if (go_rd || go_wr)
        column[ba*COLWIDTH +: COLWIDTH] <= addr_col;
      if (go_wr)
        rd_o_wr[ba] <= 1'b1;
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        if (ras[b] != '0) ras[b] <= ras[b] - 1'b1;
        if (tcnt[b] != '0) tcnt[b] <= tcnt[b] - 1'b1;
        // state flips on the edge where the counter lands on 0
        unique case (st[b])
          IDLE: begin
            if (go_act && sel[b]) begin
              st[b]   <= (TRCD == 1) ? ACTIVE : OPENING;
              tcnt[b] <= RCD_L;
              ras[b]  <= RAS_L;
              open_row[b*CHWIDTH +: CHWIDTH] <= addr_row;
            end
          end
          OPENING: begin
            if (tcnt[b] < 8'd2) st[b] <= ACTIVE;
          end
          ACTIVE: begin
            if ((go_pre && sel[b]) || go_prea) begin
              st[b]   <= (TRP == 1) ? IDLE : CLOSING;
              tcnt[b] <= RP_L;
            end
          end
          CLOSING: begin
            if (tcnt[b] < 8'd2) st[b] <= IDLE;
          end
          default: st[b] <= IDLE;
        endcase
      end
    end
  end

`ifdef BANK_GROUP_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (err && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: doc/bank_group_ctrl.md
Name: bank_group_ctrl

Overview:
- Parametrised successor to the plain bank-group bundle: adds one per-bank state machine with DRAM timing counters, a shared command decoder and a read-latency pipeline.
- Drives the per-bank bundled arrays (rd_o_wr, row, column) that feed the bank storage instances.
- Sits between the channel command front-end and the bank array inside one bank group.

Parameters:
- BAWIDTH, 2, bank address width.
- BANKSPERGROUP, 2**BAWIDTH, number of banks.
- COLWIDTH, 10, column address width.
- CHWIDTH, 5, row address width.
- TRCD, 3, cycles from ACT to first RD/WR (>=1).
- TRAS, 6, minimum cycles from ACT to PRE (>=TRCD).
- TRP, 3, cycles from PRE to bank idle (>=1).
- CL, 4, cycles from RD accept to rd_valid (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present this cycle.
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA; 6-7 illegal.
- ba  in  BAWIDTH  target bank.
- addr_row  in  CHWIDTH  row for ACT.
- addr_col  in  COLWIDTH  column for RD/WR.
- cmd_err  out  1  one-cycle pulse: command rejected.
- bank_open  out  BANKSPERGROUP  bit b=1 when bank b is in ACTIVE.
- open_row  out  CHWIDTH x BANKSPERGROUP  latched row per bank.
- rd_o_wr  out  1 x BANKSPERGROUP  per-bank write strobe to bank storage.
- row  out  CHWIDTH x BANKSPERGROUP  per-bank row to bank storage.
- column  out  COLWIDTH x BANKSPERGROUP  per-bank column to bank storage.
- rd_valid  out  1  read data valid at bank output.
- rd_ba  out  BAWIDTH  bank whose read completes with rd_valid.

Behaviour:
- Reset:
  - All banks go to IDLE; all counters 0.
  - open_row, row and column are 0.
  - rd_o_wr, bank_open, cmd_err, rd_valid and rd_ba are 0.
  - The read pipeline is flushed. Reset mid-operation discards in-flight reads; no rd_valid follows.
- Per-bank FSM:
  - IDLE -> ACTIVATING on accepted ACT. Latches addr_row into open_row and row; loads tRCD counter = TRCD-1 and tRAS counter = TRAS-1.
  - ACTIVATING -> ACTIVE when tRCD counter reaches 0. The tRAS counter keeps decrementing in all states until 0.
  - ACTIVE -> PRECHARGING on accepted PRE or PREA; loads tRP counter = TRP-1.
  - PRECHARGING -> IDLE when tRP counter reaches 0.
- Command legality:
  - Commands are evaluated only when cmd_valid=1.
  - ACT is legal in IDLE only.
  - RD/WR are legal in ACTIVE only.
  - PRE is legal in ACTIVE with tRAS counter 0; PRE to an IDLE bank is a legal no-op.
  - PREA is legal iff every ACTIVE bank has tRAS=0. It precharges all ACTIVE banks and leaves non-ACTIVE banks untouched.
  - ACT/RD/WR/PRE to ACTIVATING or PRECHARGING banks are illegal, as are opcodes 6-7.
  - An illegal command pulses cmd_err on the next cycle and causes no state change. NOP never errors.
- RD/WR:
  - Accepted RD/WR drives column[ba]=addr_col (registered, visible next cycle); row[ba] holds open_row.
  - WR pulses rd_o_wr[ba]=1 for exactly one cycle, next cycle. RD keeps rd_o_wr[ba]=0.
- Read pipeline:
  - CL-deep shift register of {valid, ba}.
  - An RD accepted at cycle N gives rd_valid=1 with rd_ba=ba at cycle N+CL.
  - Back-to-back RDs (one per cycle, any banks) produce back-to-back rd_valid pulses.
  - A PRE after RD does not cancel a read already in flight.
- One command per cycle; no backpressure. Counter state is unaffected by cmd_valid=0.

Optional Feature:
- BANK_GROUP_ERRCNT_EN defined:
  - Adds output err_count (16 bits), incremented on each cmd_err pulse.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- ACT bank1 row 5 at cycle 0; RD bank1 col 0x3A at cycle 3 -> accepted, column[1]=0x3A at cycle 4, rd_valid=1 with rd_ba=1 at cycle 7, open_row[1]=5, no cmd_err.
- ACT bank0 at cycle 0; RD bank0 at cycle 1 -> cmd_err pulse at cycle 2, no rd_valid, bank0 reaches ACTIVE at cycle 3.
- ACT bank2 at cycle 0; PRE at cycle 3 -> cmd_err. PRE at cycle 6 -> accepted, bank_open[2]=0 from cycle 7, bank2 IDLE after 3 cycles, next ACT accepted.
- Banks 0 and 3 ACTIVE with tRAS met; PREA -> both precharge and return to IDLE. Repeat with bank 3 tRAS unmet -> cmd_err, neither bank changes.
- WR bank1 col 7 -> rd_o_wr[1] high exactly one cycle with column[1]=7. RDs to banks 0,1,2 on consecutive cycles -> rd_valid high 3 consecutive cycles with rd_ba 0,1,2.
- Assert rst with 2 reads in flight -> all outputs 0 immediately (asynchronous), no rd_valid afterwards. With BANK_GROUP_ERRCNT_EN, 3 illegal commands -> err_count=3, then reset -> 0.
